uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UartTX transmitter between two requesters. Each requester hands
// over a word through a valid/ready handshake into a one-entry holding
// register. The arbiter moves one held word at a time into tx_data, pulses
// tx_load, and then follows tx_busy through the transmission. If the
// transmitter never acknowledges the load by raising tx_busy, the word is
// dropped and a sticky error flag is raised.
//
// Build option:
//   UART_ARB_ROUND_ROBIN_EN  defined   -> a tie goes to the requester that did
//                                         not win the last completed transfer
//                            undefined -> requester 0 always wins a tie
//
// Parameters:
//   WIDTH          width of a requester word and of tx_data
//   START_TIMEOUT  cycles to wait for tx_busy to rise after the load pulse
//
// Ports:
//   CLK_100MHz   in   clock, all state changes on its rising edge
//   rst_n        in   asynchronous active-low reset
//   req0_valid   in   requester 0 word valid
//   req0_data    in   requester 0 word [WIDTH]
//   req0_ready   out  requester 0 holding register empty
//   req1_valid   in   requester 1 word valid
//   req1_data    in   requester 1 word [WIDTH]
//   req1_ready   out  requester 1 holding register empty
//   tx_load      out  one-cycle load pulse to UartTX
//   tx_data      out  word presented to UartTX [WIDTH]
//   tx_busy      in   busy flag from UartTX
//   grant        out  one-hot transmitter owner, 00 = no owner [2]
//   err          out  sticky start-timeout flag
//   err_clear    in   clears err (a simultaneous timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int WIDTH         = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic             CLK_100MHz,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             tx_load,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_busy,
  output logic [1:0]       grant,
  output logic             err,
  input  logic             err_clear
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int               CNT_W    = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic             hold0_full;
  logic             hold1_full;
  logic [WIDTH-1:0] hold0_data;
  logic [WIDTH-1:0] hold1_data;

  logic             start;
  logic             pick1;
  logic             take0;
  logic             take1;
  logic             timeout;

  // ---------------------------------------------------------------------------
  // Requester handshake: ready is simply "holding register empty", so a
  // register emptied by the arbiter cannot be refilled on the same edge and
  // ready reappears one cycle after the take.
  // ---------------------------------------------------------------------------
  assign req0_ready = ~hold0_full;
  assign req1_ready = ~hold1_full;

  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      hold0_full <= 1'b0;
      hold1_full <= 1'b0;
    end else begin
      // take and accept are mutually exclusive: take needs full, accept empty
      if (take0)
        hold0_full <= 1'b0;
      else if (req0_valid && !hold0_full)
        hold0_full <= 1'b1;

      if (take1)
        hold1_full <= 1'b0;
      else if (req1_valid && !hold1_full)
        hold1_full <= 1'b1;
    end
  end

  // Holding data carries no reset; the full flags qualify it.
  always_ff @(posedge CLK_100MHz) begin
    if (req0_valid && !hold0_full)
      hold0_data <= req0_data;
    if (req1_valid && !hold1_full)
      hold1_data <= req1_data;
  end

  // ---------------------------------------------------------------------------
  // Arbitration: a grant only starts from IDLE with the transmitter idle.
  // ---------------------------------------------------------------------------
  assign start = (state == ST_IDLE) && (hold0_full || hold1_full) && !tx_busy;

`ifdef UART_ARB_ROUND_ROBIN_EN
  // last_winner: 0 = requester 0, 1 = requester 1. Reset value 1 lets
  // requester 0 take the first tie.
  logic last_winner;

  always_comb begin
    pick1 = hold1_full;
    if (hold0_full && hold1_full)
      pick1 = ~last_winner;
  end

  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n)
      last_winner <= 1'b1;
    else if (state == ST_WAIT_DONE && !tx_busy)
      last_winner <= grant[1];
  end
`else
  // Fixed priority: requester 1 only wins when requester 0 has nothing held.
  assign pick1 = hold1_full & ~hold0_full;
`endif

  assign take0 = start & ~pick1;
  assign take1 = start &  pick1;

  // The start timeout fires on the cycle the counter would reach
  // START_TIMEOUT, i.e. after START_TIMEOUT busy-low cycles in WAIT_BUSY.
  assign timeout = (state == ST_WAIT_BUSY) && !tx_busy && (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Transfer FSM. tx_load is a registered output produced by the LOAD state,
  // so it is seen by UartTX one edge after the FSM leaves LOAD; the timeout
  // window therefore already includes the cycle the load pulse is visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      tx_load <= 1'b0;
      tx_data <= '0;
      grant   <= 2'b00;
    end else begin
      tx_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            tx_data <= pick1 ? hold1_data : hold0_data;
            grant   <= pick1 ? 2'b10 : 2'b01;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tx_load <= 1'b1;
          cnt     <= '0;
          state   <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (timeout) begin
            // Transmitter never started: drop the word and release the owner.
            cnt   <= '0;
            grant <= 2'b00;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            grant <= 2'b00;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error: a timeout on the same edge as err_clear keeps err set.
  always_ff @(posedge CLK_100MHz or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (timeout)
      err <= 1'b1;
    else if (err_clear)
      err <= 1'b0;
  end

endmodule
